// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: records first rise/fall of each monitored bit
// and streams each newly covered point once through a valid/ready stage.
module toggle_cover_collector #(
  parameter int WIDTH       = 65,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               sig_in,
  input  logic                           sample_en,
  input  logic                           clear,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [IDX_W-1:0]               evt_index,
  output logic [$clog2(2*WIDTH+1)-1:0]   covered_count,
  output logic                           all_covered
);

  localparam int NP    = 2 * WIDTH;
  localparam int CNT_W = $clog2(NP + 1);
  localparam int PW    = (NP > 1) ? $clog2(NP) : 1;

  logic [WIDTH-1:0] prev;
  logic             armed;
  logic [NP-1:0]    covered;
  logic [NP-1:0]    pending;

  logic [NP-1:0]    hit;
  logic [NP-1:0]    fresh;
  logic [CNT_W-1:0] fresh_cnt;
  logic             any;
  logic [PW-1:0]    pick;
  logic             load;
  logic             take;
  logic [NP-1:0]    take_mask;

  // Edge detection against the previous sample, filtered to first hits
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[2*i]   = sample_en & armed & ~prev[i] & sig_in[i];
      hit[2*i+1] = sample_en & armed & prev[i] & ~sig_in[i];
    end
    fresh = hit & ~covered;
  end

  // Number of points that become covered this cycle
  always_comb begin
    fresh_cnt = '0;
    for (int i = 0; i < NP; i++) begin
      fresh_cnt = fresh_cnt + CNT_W'(fresh[i]);
    end
  end

  // Lowest-numbered pending point wins the output stage
  always_comb begin
    any  = 1'b0;
    pick = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (pending[i]) begin
        any  = 1'b1;
        pick = PW'(i);
      end
    end
  end

  // Output stage load control and the pending bit it retires
  always_comb begin
    load      = ~evt_valid | evt_ready;
    take      = load & any;
    take_mask = '0;
    if (take) begin
      take_mask[pick] = 1'b1;
    end
  end

  // Sample register: prev follows sig_in even during clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev <= '0;
    end else if (sample_en) begin
      prev <= sig_in;
    end
  end

  // Coverage state, pending set and output stage
  always_ff @(posedge clock) begin
    if (!reset) begin
      armed         <= 1'b0;
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      evt_valid     <= 1'b0;
      evt_index     <= '0;
    end else if (clear) begin
      armed         <= 1'b0;
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      evt_valid     <= 1'b0;
    end else begin
      if (sample_en) begin
        armed <= 1'b1;
      end
      covered       <= covered | fresh;
      pending       <= (pending & ~take_mask) | fresh;
      covered_count <= covered_count + fresh_cnt;
      if (load) begin
        evt_valid <= any;
        if (any) begin
          evt_index <= IDX_W'(COVER_INDEX) + IDX_W'(pick);
        end
      end
    end
  end

  // Full coverage flag
  always_comb begin
    all_covered = (covered_count == CNT_W'(NP));
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector (WIDTH=65, COVER_INDEX=100):
// a vector table for the basic flow, loops for the full-sweep and reset cases.
module tb_toggle_cover_collector;

  localparam int W  = 65;
  localparam int CI = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  sig_in;
  logic          sample_en;
  logic          clear;
  logic          evt_valid;
  logic          evt_ready;
  logic [31:0]   evt_index;
  logic [7:0]    covered_count;
  logic          all_covered;

  int tests = 0;
  int fails = 0;
  int stepn = 0;

  toggle_cover_collector #(
    .WIDTH(W),
    .COVER_INDEX(CI),
    .IDX_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sig_in(sig_in),
    .sample_en(sample_en),
    .clear(clear),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_index(evt_index),
    .covered_count(covered_count),
    .all_covered(all_covered)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         r;
    logic         c;
    logic         rd;
    logic [W-1:0] s;
    logic         v;
    logic [31:0]  idx;
    logic [7:0]   cnt;
    logic         all;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic r, input logic c,
                              input logic rd, input logic [W-1:0] s,
                              input logic v, input logic [31:0] idx,
                              input logic [7:0] cnt, input logic all);
    vec_t t;
    t.r = r; t.c = c; t.rd = rd; t.s = s;
    t.v = v; t.idx = idx; t.cnt = cnt; t.all = all;
    return t;
  endfunction

  task automatic step(input logic r, input logic c, input logic rd,
                      input logic [W-1:0] s, input logic ev,
                      input logic [31:0] ei, input logic [7:0] ec,
                      input logic ea, input logic chk_idx,
                      input string nm);
    reset     = r;
    clear     = c;
    evt_ready = rd;
    sig_in    = s;
    sample_en = 1'b1;
    @(posedge clock);
    #1;
    stepn++;
    tests++;
    if (evt_valid !== ev) begin
      fails++;
      $display("FAIL %s step %0d evt_valid got %0b want %0b",
               nm, stepn, evt_valid, ev);
    end
    tests++;
    if (covered_count !== ec) begin
      fails++;
      $display("FAIL %s step %0d covered_count got %0d want %0d",
               nm, stepn, covered_count, ec);
    end
    tests++;
    if (all_covered !== ea) begin
      fails++;
      $display("FAIL %s step %0d all_covered got %0b want %0b",
               nm, stepn, all_covered, ea);
    end
    if (chk_idx) begin
      tests++;
      if (evt_index !== ei) begin
        fails++;
        $display("FAIL %s step %0d evt_index got %0d want %0d",
                 nm, stepn, evt_index, ei);
      end
    end
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] b3;

  initial begin
    ones = '1;
    b3   = W'(8);
    reset = 1'b0; clear = 1'b0; evt_ready = 1'b1;
    sig_in = '0; sample_en = 1'b1;

    tbl[0]  = mk(0, 0, 1, '0,      0, 0,   0, 0);
    tbl[1]  = mk(1, 0, 1, '0,      0, 0,   0, 0);
    tbl[2]  = mk(1, 0, 1, '0,      0, 0,   0, 0);
    tbl[3]  = mk(1, 0, 1, b3,      0, 0,   1, 0);
    tbl[4]  = mk(1, 0, 1, b3,      1, 106, 1, 0);
    tbl[5]  = mk(1, 0, 1, '0,      0, 0,   2, 0);
    tbl[6]  = mk(1, 0, 1, '0,      1, 107, 2, 0);
    tbl[7]  = mk(1, 0, 1, b3,      0, 0,   2, 0);
    tbl[8]  = mk(1, 0, 1, b3,      0, 0,   2, 0);
    tbl[9]  = mk(1, 0, 0, W'(15),  0, 0,   5, 0);
    tbl[10] = mk(1, 0, 0, W'(15),  1, 100, 5, 0);
    tbl[11] = mk(1, 0, 0, W'(15),  1, 100, 5, 0);
    tbl[12] = mk(1, 0, 0, W'(15),  1, 100, 5, 0);
    tbl[13] = mk(1, 0, 0, W'(15),  1, 100, 5, 0);
    tbl[14] = mk(1, 0, 1, W'(15),  1, 102, 5, 0);
    tbl[15] = mk(1, 0, 1, W'(15),  1, 104, 5, 0);
    tbl[16] = mk(1, 0, 1, W'(15),  0, 0,   5, 0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].rd, tbl[i].s, tbl[i].v,
           tbl[i].idx, tbl[i].cnt, tbl[i].all,
           (i == 0) || tbl[i].v, "table");
    end

    // clear while an event is valid and another is pending
    step(1, 0, 0, W'(63), 0, 0,   7, 0, 0, "clr_fill");
    step(1, 0, 0, W'(63), 1, 108, 7, 0, 1, "clr_fill");
    step(1, 1, 0, W'(63), 0, 0,   0, 0, 0, "clr_edge");
    step(1, 0, 1, '0,     0, 0,   0, 0, 0, "clr_arm");
    step(1, 0, 1, '0,     0, 0,   0, 0, 0, "clr_idle");

    // full sweep: all rises, then all falls, one event per cycle
    step(1, 0, 1, ones, 0, 0, 65, 0, 0, "rise_det");
    for (int k = 0; k < W; k++) begin
      step(1, 0, 1, ones, 1, 32'(CI + 2*k), 65, 0, 1, "rise_evt");
    end
    step(1, 0, 1, '0, 0, 0, 130, 1, 0, "fall_det");
    for (int k = 0; k < W; k++) begin
      step(1, 0, 1, '0, 1, 32'(CI + 2*k + 1), 130, 1, 1, "fall_evt");
    end
    step(1, 0, 1, '0, 0, 0, 130, 1, 0, "sweep_end");

    // reset mid-stream drops pending events
    step(1, 1, 1, '0,     0, 0,   0, 0, 0, "rst_clr");
    step(1, 0, 1, '0,     0, 0,   0, 0, 0, "rst_arm");
    step(1, 0, 1, W'(7),  0, 0,   3, 0, 0, "rst_fill");
    step(1, 0, 1, W'(7),  1, 100, 3, 0, 1, "rst_fill");
    step(0, 0, 1, W'(7),  0, 0,   0, 0, 1, "rst_edge");
    step(1, 0, 1, W'(7),  0, 0,   0, 0, 0, "rst_arm2");
    step(1, 0, 1, W'(7),  0, 0,   0, 0, 0, "rst_quiet");
    step(1, 0, 1, W'(7),  0, 0,   0, 0, 0, "rst_quiet");
    step(1, 0, 1, W'(15), 0, 0,   1, 0, 0, "rst_new");
    step(1, 0, 1, W'(15), 1, 106, 1, 0, 1, "rst_new");
    step(1, 0, 1, W'(15), 0, 0,   1, 0, 0, "rst_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
